// File: rtl/avalon_sdr_responder_if.sv
// Avalon-MM bus bundle between the SDR master and the word-buffer responder.
interface avalon_sdr_responder_if;
    logic [31:0] avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [15:0] avs_s0_writedata;
    logic [1:0]  avs_s0_byteenable;
    logic [15:0] avs_s0_readdata;
    logic        avs_s0_readdatavalid;
    logic        avs_s0_waitrequest;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata, avs_s0_byteenable,
        input  avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata, avs_s0_byteenable,
        output avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
    );
endinterface

// File: rtl/avalon_sdr_responder.sv
// Avalon-MM 16-bit responder over a DEPTH-word buffer: programmable wait states,
// fixed pipelined read latency, host side-port and sticky access-error flags.
module avalon_sdr_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
    input  logic                     clk,
    input  logic                     reset,
    avalon_sdr_responder_if.slave    avs,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic                     host_we,
    input  logic [15:0]              host_wdata,
    output logic [15:0]              host_rdata,
    output logic                     err_range,
    output logic                     err_unaligned,
    output logic                     err_rw
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [32:0] LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(2 * DEPTH);

    logic [3:0]              cnt_q, cnt_d;
    logic                    req, accept, wr_acc, rd_acc, in_range, av_hit;
    logic [AW-1:0]           word;
    logic [15:0]             mem [DEPTH];
    logic [15:0]             rd_word, wr_merged, host_next;
    logic [READ_LATENCY-1:0] pv_q;
    logic [15:0]             pd_q [READ_LATENCY];
    logic [15:0]             host_rdata_q;
    logic                    err_range_q, err_unaligned_q, err_rw_q;

    assign req    = avs.avs_s0_read | avs.avs_s0_write;
    assign avs.avs_s0_waitrequest = reset | ~(req && (cnt_q == 4'(WAIT_CYCLES)));
    assign accept = req & ~avs.avs_s0_waitrequest;
    // read+write together is handled purely as a write
    assign wr_acc = accept & avs.avs_s0_write;
    assign rd_acc = accept & avs.avs_s0_read & ~avs.avs_s0_write;

    assign in_range = ({1'b0, avs.avs_s0_address} >= LO) && ({1'b0, avs.avs_s0_address} < HI);
    assign word     = AW'((avs.avs_s0_address - BASE_ADDR) >> 1);
    assign av_hit   = wr_acc & in_range;
    assign rd_word  = mem[word];
    assign wr_merged = {avs.avs_s0_byteenable[1] ? avs.avs_s0_writedata[15:8] : rd_word[15:8],
                        avs.avs_s0_byteenable[0] ? avs.avs_s0_writedata[7:0]  : rd_word[7:0]};

    always_comb begin
        cnt_d = cnt_q;
        if (!req || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // host_rdata shows the word as it will be after this cycle's writes
    always_comb begin
        host_next = mem[host_addr];
        if (av_hit && (word == host_addr)) begin
            host_next = wr_merged;
        end else if (host_we) begin
            host_next = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (host_we && !(av_hit && (word == host_addr))) begin
            mem[host_addr] <= host_wdata;
        end
        if (av_hit) begin
            mem[word] <= wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q           <= '0;
            host_rdata_q    <= '0;
            err_range_q     <= 1'b0;
            err_unaligned_q <= 1'b0;
            err_rw_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            host_rdata_q <= host_next;
            if (accept && !in_range) begin
                err_range_q <= 1'b1;
            end
            if (accept && avs.avs_s0_address[0]) begin
                err_unaligned_q <= 1'b1;
            end
            if (accept && avs.avs_s0_read && avs.avs_s0_write) begin
                err_rw_q <= 1'b1;
            end
        end
    end

    // Data stages only advance behind a valid entry, so the output holds its last read value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                pd_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= rd_acc;
            if (rd_acc) begin
                pd_q[0] <= in_range ? rd_word : ERR_DATA;
            end
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
                if (pv_q[k-1]) begin
                    pd_q[k] <= pd_q[k-1];
                end
            end
        end
    end

    assign avs.avs_s0_readdatavalid = pv_q[READ_LATENCY-1];
    assign avs.avs_s0_readdata      = pd_q[READ_LATENCY-1];
    assign host_rdata    = host_rdata_q;
    assign err_range     = err_range_q;
    assign err_unaligned = err_unaligned_q;
    assign err_rw        = err_rw_q;
endmodule

// File: tb/tb_avalon_sdr_responder.sv
// Bench for avalon_sdr_responder: one instance with wait states, one zero-wait instance
// for back-to-back traffic, both checked against an array-based model of the buffer.
module tb_avalon_sdr_responder;
    localparam logic [31:0] A_BASE = 32'h0000_1000;
    localparam int A_DEPTH = 16;
    localparam int A_WAIT  = 2;
    localparam int A_LAT   = 2;
    localparam logic [31:0] B_BASE = 32'h0000_0000;
    localparam int B_DEPTH = 16;
    localparam int B_WAIT  = 0;
    localparam int B_LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  host_addr_a, host_addr_b;
    logic        host_we_a, host_we_b;
    logic [15:0] host_wdata_a, host_wdata_b, host_rdata_a, host_rdata_b;
    logic        err_range_a, err_unal_a, err_rw_a, err_range_b, err_unal_b, err_rw_b;

    avalon_sdr_responder_if a_if ();
    avalon_sdr_responder_if b_if ();

    avalon_sdr_responder #(.BASE_ADDR(A_BASE), .DEPTH(A_DEPTH), .WAIT_CYCLES(A_WAIT),
                           .READ_LATENCY(A_LAT), .ERR_DATA(16'hDEAD)) dut_a (
        .clk(clk), .reset(rst_a), .avs(a_if),
        .host_addr(host_addr_a), .host_we(host_we_a), .host_wdata(host_wdata_a),
        .host_rdata(host_rdata_a), .err_range(err_range_a), .err_unaligned(err_unal_a),
        .err_rw(err_rw_a)
    );

    avalon_sdr_responder #(.BASE_ADDR(B_BASE), .DEPTH(B_DEPTH), .WAIT_CYCLES(B_WAIT),
                           .READ_LATENCY(B_LAT), .ERR_DATA(16'hDEAD)) dut_b (
        .clk(clk), .reset(rst_b), .avs(b_if),
        .host_addr(host_addr_b), .host_we(host_we_b), .host_wdata(host_wdata_b),
        .host_rdata(host_rdata_b), .err_range(err_range_b), .err_unaligned(err_unal_b),
        .err_rw(err_rw_b)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        hwe;
        logic [3:0]  ha;
        logic [15:0] hwd;
    } op_t;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [15:0] m_a [A_DEPTH];
    logic [15:0] m_b [B_DEPTH];
    bit ea_r, ea_u, ea_w, eb_r, eb_u, eb_w;
    int unsigned a_rd_exp = 0;
    int unsigned a_rdv_seen = 0;
    op_t b_ops[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] wd,
                                            input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    function automatic bit in_win(input longint a, input longint base, input longint depth);
        return (a >= base) && (a < base + 2 * depth);
    endfunction

    function automatic logic [31:0] rand_addr(input logic [31:0] base, input int depth);
        case ($urandom_range(0, 9))
            0: return base + 32'(2 * depth) + 32'(2 * $urandom_range(0, 3));
            1: return base - 32'd2;
            2: return 32'hFFFF_FFFE;
            3: return base + 32'(2 * $urandom_range(0, depth - 1)) + 32'd1;
            default: return base + 32'(2 * $urandom_range(0, depth - 1));
        endcase
    endfunction

    function automatic op_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [15:0] wd, input logic [1:0] be,
                               input bit hwe, input logic [3:0] ha, input logic [15:0] hwd);
        op_t o;
        o.rd = rd; o.wr = wr; o.addr = addr; o.wd = wd; o.be = be;
        o.hwe = hwe; o.ha = ha; o.hwd = hwd;
        return o;
    endfunction

    always @(negedge clk) begin
        if (a_if.avs_s0_readdatavalid === 1'b1) a_rdv_seen++;
    end

    // One Avalon command on instance A, including stall count and read latency checks.
    task automatic a_cmd(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
        longint a;
        longint w;
        bit inr, acc, seen;
        int unsigned stalls, lat;
        logic [15:0] exp_d;
        a = addr;
        inr = in_win(a, A_BASE, A_DEPTH);
        w = 0;
        exp_d = 16'hDEAD;
        if (inr) begin
            w = (a - longint'(A_BASE)) / 2;
            exp_d = m_a[int'(w)];
        end
        acc = 0; seen = 0; stalls = 0; lat = 0;
        @(posedge clk); #1;
        a_if.avs_s0_read = rd; a_if.avs_s0_write = wr; a_if.avs_s0_address = addr;
        a_if.avs_s0_writedata = wd; a_if.avs_s0_byteenable = be;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_if.avs_s0_waitrequest) begin
                acc = 1;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        a_if.avs_s0_read = 1'b0; a_if.avs_s0_write = 1'b0;
        check_eq($sformatf("a_accept@%h", addr), 32'(acc), 32'd1);
        check_eq($sformatf("a_stalls@%h", addr), stalls, A_WAIT);
        if (acc) begin
            if (!inr) ea_r = 1;
            if (addr[0]) ea_u = 1;
            if (rd && wr) ea_w = 1;
            if (wr && inr) m_a[int'(w)] = merge16(m_a[int'(w)], wd, be);
            if (rd && !wr) begin
                a_rd_exp++;
                for (int i = 0; i < A_LAT + 4; i++) begin
                    lat++;
                    @(negedge clk);
                    if (a_if.avs_s0_readdatavalid) begin
                        seen = 1;
                        break;
                    end
                end
                check_eq($sformatf("a_rd_latency@%h", addr), lat, A_LAT);
                if (seen) check_eq($sformatf("a_rdata@%h", addr), a_if.avs_s0_readdata, exp_d);
            end
        end
    endtask

    task automatic a_host_wr(input int i, input logic [15:0] d);
        @(posedge clk); #1;
        host_we_a = 1'b1; host_addr_a = 4'(i); host_wdata_a = d;
        @(posedge clk); #1;
        host_we_a = 1'b0;
        m_a[i] = d;
    endtask

    task automatic a_host_chk(input int i);
        @(posedge clk); #1;
        host_addr_a = 4'(i);
        @(posedge clk); #1;
        check_eq($sformatf("a_host_rdata[%0d]", i), host_rdata_a, m_a[i]);
    endtask

    task automatic a_flags(input string tag);
        check_eq({tag, "_err_range"}, err_range_a, ea_r);
        check_eq({tag, "_err_unal"}, err_unal_a, ea_u);
        check_eq({tag, "_err_rw"}, err_rw_a, ea_w);
    endtask

    task automatic b_flags(input string tag);
        check_eq({tag, "_err_range"}, err_range_b, eb_r);
        check_eq({tag, "_err_unal"}, err_unal_b, eb_u);
        check_eq({tag, "_err_rw"}, err_rw_b, eb_w);
    endtask

    // Plays queued ops on zero-wait instance B, one per cycle, and checks every cycle.
    task automatic b_run();
        int n, ncyc;
        bit ev [256];
        bit hv [256];
        logic [15:0] ed [256];
        logic [15:0] eh [256];
        op_t op;
        longint a, w;
        bit inr, hit;
        n = b_ops.size();
        ncyc = n + B_LAT + 2;
        for (int i = 0; i < 256; i++) begin
            ev[i] = 0; hv[i] = 0; ed[i] = '0; eh[i] = '0;
        end
        for (int c = 0; c < ncyc; c++) begin
            op = (c < n) ? b_ops[c] : '0;
            @(posedge clk); #1;
            b_if.avs_s0_read = op.rd; b_if.avs_s0_write = op.wr; b_if.avs_s0_address = op.addr;
            b_if.avs_s0_writedata = op.wd; b_if.avs_s0_byteenable = op.be;
            host_we_b = op.hwe; host_addr_b = op.ha; host_wdata_b = op.hwd;
            a = op.addr;
            inr = in_win(a, B_BASE, B_DEPTH);
            w = inr ? (a - longint'(B_BASE)) / 2 : 0;
            if (op.rd || op.wr) begin
                if (!inr) eb_r = 1;
                if (op.addr[0]) eb_u = 1;
                if (op.rd && op.wr) eb_w = 1;
            end
            if (op.rd && !op.wr) begin
                ev[c + B_LAT] = 1;
                ed[c + B_LAT] = inr ? m_b[int'(w)] : 16'hDEAD;
            end
            hit = op.wr && inr;
            if (op.hwe && !(hit && (int'(w) == int'(op.ha)))) m_b[op.ha] = op.hwd;
            if (hit) m_b[int'(w)] = merge16(m_b[int'(w)], op.wd, op.be);
            eh[c + 1] = m_b[op.ha];
            hv[c + 1] = 1;
            @(negedge clk);
            check_eq($sformatf("b_wait[%0d]", c), b_if.avs_s0_waitrequest, 32'(!(op.rd || op.wr)));
            check_eq($sformatf("b_rdv[%0d]", c), b_if.avs_s0_readdatavalid, 32'(ev[c]));
            if (ev[c]) check_eq($sformatf("b_rdata[%0d]", c), b_if.avs_s0_readdata, ed[c]);
            if (hv[c]) check_eq($sformatf("b_host_rdata[%0d]", c), host_rdata_b, eh[c]);
        end
        b_ops.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        host_we_a = 0; host_addr_a = '0; host_wdata_a = '0;
        host_we_b = 0; host_addr_b = '0; host_wdata_b = '0;
        a_if.avs_s0_read = 0; a_if.avs_s0_write = 0; a_if.avs_s0_address = '0;
        a_if.avs_s0_writedata = '0; a_if.avs_s0_byteenable = '0;
        b_if.avs_s0_read = 0; b_if.avs_s0_write = 0; b_if.avs_s0_address = '0;
        b_if.avs_s0_writedata = '0; b_if.avs_s0_byteenable = '0;
        ea_r = 0; ea_u = 0; ea_w = 0; eb_r = 0; eb_u = 0; eb_w = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_wait", a_if.avs_s0_waitrequest, 1);
        check_eq("rst_a_rdv", a_if.avs_s0_readdatavalid, 0);
        check_eq("rst_a_rdata", a_if.avs_s0_readdata, 0);
        check_eq("rst_a_host_rdata", host_rdata_a, 0);
        a_flags("rst_a");
        check_eq("rst_b_wait", b_if.avs_s0_waitrequest, 1);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // Instance A: directed scenarios then random single commands
        for (int i = 0; i < A_DEPTH; i++) a_host_wr(i, 16'($urandom));
        a_cmd(0, 1, A_BASE + 32'd4, 16'h1234, 2'b11);
        a_cmd(1, 0, A_BASE + 32'd4, 16'h0000, 2'b00);
        a_host_wr(3, 16'hAAAA);
        a_cmd(0, 1, A_BASE + 32'd6, 16'h55CC, 2'b01);
        a_cmd(1, 0, A_BASE + 32'd6, 16'h0000, 2'b00);
        a_host_chk(3);
        a_cmd(1, 0, A_BASE + 32'(2 * A_DEPTH), 16'h0000, 2'b00);
        a_flags("a_range_rd");
        a_cmd(0, 1, A_BASE + 32'(2 * A_DEPTH), 16'hBEEF, 2'b11);
        a_cmd(0, 1, A_BASE - 32'd2, 16'hBEEF, 2'b11);
        a_cmd(0, 1, A_BASE + 32'd8, 16'hFFFF, 2'b00);
        a_cmd(1, 0, A_BASE + 32'd30, 16'h0000, 2'b00);
        a_cmd(1, 1, A_BASE + 32'd10, 16'h7777, 2'b11);
        a_flags("a_directed");
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 9);
            a_cmd(k < 5, k >= 4, rand_addr(A_BASE, A_DEPTH), 16'($urandom), 2'($urandom));
        end
        for (int i = 0; i < A_DEPTH; i++) a_host_chk(i);
        a_flags("a_random");
        check_eq("a_rdv_count", a_rdv_seen, a_rd_exp);

        // Instance B: preload, back-to-back reads, write-then-read ordering, side-port collision
        for (int i = 0; i < B_DEPTH; i++) b_ops.push_back(mk(0, 0, 0, 0, 0, 1, 4'(i), 16'($urandom)));
        b_run();
        for (int i = 0; i < 8; i++) b_ops.push_back(mk(1, 0, B_BASE + 32'(2 * i), 0, 0, 0, 4'(i), 0));
        b_run();
        b_ops.push_back(mk(0, 1, B_BASE + 32'd18, 16'($urandom), 2'b11, 0, 4'd9, 0));
        b_ops.push_back(mk(1, 0, B_BASE + 32'd18, 0, 0, 0, 4'd9, 0));
        b_ops.push_back(mk(0, 1, B_BASE + 32'd18, 16'($urandom), 2'b10, 0, 4'd9, 0));
        b_ops.push_back(mk(1, 0, B_BASE + 32'd18, 0, 0, 0, 4'd9, 0));
        b_run();
        b_ops.push_back(mk(0, 1, B_BASE + 32'd10, 16'h0002, 2'b11, 1, 4'd5, 16'h0001));
        b_ops.push_back(mk(1, 0, B_BASE + 32'd11, 0, 0, 0, 4'd5, 0));
        b_run();
        b_flags("b_directed");
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 9);
            b_ops.push_back(mk(k < 5, (k >= 4) && (k != 9), rand_addr(B_BASE, B_DEPTH),
                               16'($urandom), 2'($urandom), $urandom_range(0, 3) == 0,
                               4'($urandom), 16'($urandom)));
        end
        b_run();
        b_flags("b_random");

        // Reset with two reads in flight and a command stalled under reset
        @(posedge clk); #1;
        b_if.avs_s0_read = 1'b1; b_if.avs_s0_address = B_BASE;
        @(posedge clk); #1;
        b_if.avs_s0_address = B_BASE + 32'd2;
        @(posedge clk); #1;
        rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_mid_wait[%0d]", i), b_if.avs_s0_waitrequest, 1);
            check_eq($sformatf("rst_mid_rdv[%0d]", i), b_if.avs_s0_readdatavalid, 0);
            @(posedge clk); #1;
        end
        rst_b = 1'b0;
        b_if.avs_s0_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_post_rdv[%0d]", i), b_if.avs_s0_readdatavalid, 0);
        end
        check_eq("rst_post_rdata", b_if.avs_s0_readdata, 0);
        eb_r = 0; eb_u = 0; eb_w = 0;
        b_flags("rst_post");
        for (int i = 0; i < B_DEPTH; i++) b_ops.push_back(mk(1, 0, B_BASE + 32'(2 * i), 0, 0, 0, 4'(i), 0));
        b_run();
        b_flags("b_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
